pc_unit: RTL
============

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter register; successor to the plain PC latch. Holds the
//  fetch address, self-increments, accepts redirects/traps, handshakes with fetch,
//  supports halt/resume. Sits between branch/exec resolution and instruction fetch.
// PARAMETERS
//  XLEN          32            PC width in bits
//  RESET_VECTOR  32'h0000_0000 PC value loaded on reset
//  INCR          4             byte increment per accepted fetch
//  ALIGN_BITS    2             low target bits that must be zero
//  RAS_DEPTH     4             return-address-stack entries (PC_RAS_EN only), power of 2
// PORTS
//  CLK              in   1     clock, rising edge
//  RST_N            in   1     synchronous reset, active low
//  PC_OUT           out  XLEN  current fetch address
//  PC_VALID         out  1     PC_OUT valid for fetch
//  FETCH_READY      in   1     fetch accepts PC_OUT this cycle
//  REDIRECT         in   1     branch/jump taken
//  REDIRECT_TARGET  in   XLEN  redirect destination
//  TRAP             in   1     trap request
//  TRAP_VECTOR      in   XLEN  trap destination
//  HALT_REQ         in   1     request halt
//  RESUME           in   1     leave halt
//  HALTED           out  1     unit halted
//  MISALIGN         out  1     1-cycle pulse: loaded target had nonzero align bits
//  CALL, RET        in   1     (PC_RAS_EN only) push PC_OUT+INCR / pop as target
//  RAS_EMPTY        out  1     (PC_RAS_EN only) stack empty
// BEHAVIOUR
//  - Reset (RST_N=0 at edge): PC_OUT=RESET_VECTOR, PC_VALID=0, HALTED=0, MISALIGN=0,
//    state=BOOT, RAS cleared. Mid-operation reset overrides every other input.
//  - States: BOOT -> RUN after 1 cycle (PC_VALID=1 from RUN). RUN -> HALT on HALT_REQ
//    (no higher-priority event). HALT -> RUN on RESUME; PC_VALID=0, HALTED=1 in HALT.
//  - Next-PC priority per edge, RUN: TRAP > RET > REDIRECT > accept > hold.
//    accept = PC_VALID & FETCH_READY -> PC_OUT += INCR, modulo 2^XLEN (wraps to 0).
//    no accept, no event -> PC_OUT holds (stall).
//  - TRAP/REDIRECT/RET ignore FETCH_READY; new PC visible next cycle (latency 1).
//  - TRAP in HALT: loads TRAP_VECTOR, goes RUN. REDIRECT/CALL/RET ignored in HALT/BOOT.
//  - HALT_REQ with TRAP same cycle: trap taken, halt ignored. HALT_REQ+RESUME: halt wins.
//  - Loaded target low ALIGN_BITS forced to 0; MISALIGN=1 next cycle iff any were set.
// CONFIGURATION
//  PC_RAS_EN defined: CALL pushes PC_OUT+INCR (with REDIRECT = call target); RET pops
//  top as next PC. Push on full overwrites oldest (circular). RET on empty: ignored,
//  falls through to REDIRECT/accept. CALL+RET same cycle: pop then push.
//  PC_RAS_EN undefined: CALL/RET/RAS_EMPTY ports absent; no stack logic.
// STRUCTURE
//  pc_pkg: state enum {BOOT,RUN,HALT}, next-PC source enum {SRC_HOLD,SRC_INC,
//  SRC_REDIR,SRC_RET,SRC_TRAP}, default INCR/ALIGN_BITS constants.
//  Sub-module pc_ras (circular LIFO, RAS_DEPTH x XLEN), instantiated under PC_RAS_EN.
// TESTING
//  1 reset, FETCH_READY=1 -> cycle1 PC=0 VALID=0; then 0,4,8,12 with VALID=1.
//  2 FETCH_READY=0 two cycles at PC=0x10 -> PC holds 0x10; resumes 0x14.
//  3 REDIRECT=1 target 0x103 with TRAP=1 vector 0x200 -> PC=0x200; alone -> 0x100, MISALIGN.
//  4 PC=0xFFFF_FFFC accept -> PC=0x0000_0000.
//  5 HALT_REQ at PC=0x40 -> HALTED=1, VALID=0, PC 0x40 held; RESUME -> VALID, 0x40.
//  6 PC_RAS_EN: CALL+REDIRECT 0x80 at 0x20 -> 0x80; RET -> 0x24, RAS_EMPTY=1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter unit.
// The optional return-address stack is enabled by defining PC_RAS_EN.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } pc_state_t;

    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_INC,
        SRC_REDIR,
        SRC_RET,
        SRC_TRAP
    } pc_src_t;

    localparam int unsigned PC_DEFAULT_INCR       = 4;
    localparam int unsigned PC_DEFAULT_ALIGN_BITS = 2;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push on a full stack overwrites the oldest entry.
// A simultaneous push and pop replaces the top entry. DEPTH must be a power of 2, at least 2.
module pc_ras #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   sp;
    logic [CW-1:0]   count;
    logic [PW-1:0]   top_idx;

    assign top_idx = sp - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sp    <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (pop && push) begin
            mem[top_idx] <= push_data;
        end else if (pop) begin
            sp    <= top_idx;
            count <= count - CW'(1);
        end else if (push) begin
            mem[sp] <= push_data;
            sp      <= sp + PW'(1);
            if (count != CW'(DEPTH)) begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter register with self-increment, redirect/trap, fetch handshake and halt/resume.
// Define PC_RAS_EN to add CALL/RET ports backed by a return-address stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INCR         = PC_DEFAULT_INCR,
    parameter int unsigned     ALIGN_BITS   = PC_DEFAULT_ALIGN_BITS,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    output logic [XLEN-1:0] PC_OUT,
    output logic            PC_VALID,
    input  logic            FETCH_READY,
    input  logic            REDIRECT,
    input  logic [XLEN-1:0] REDIRECT_TARGET,
    input  logic            TRAP,
    input  logic [XLEN-1:0] TRAP_VECTOR,
    input  logic            HALT_REQ,
    input  logic            RESUME,
    output logic            HALTED,
`ifdef PC_RAS_EN
    input  logic            CALL,
    input  logic            RET,
    output logic            RAS_EMPTY,
`endif
    output logic            MISALIGN
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    pc_state_t       state;
    pc_state_t       next_state;
    pc_src_t         src;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_next;
    logic            misalign_next;
    logic            run_free;
    logic            ret_ok;
    logic [XLEN-1:0] ras_top;

    // Stack only moves in RUN when neither a trap nor a halt claims the cycle.
    assign run_free = (state == RUN) && !TRAP && !HALT_REQ;

`ifdef PC_RAS_EN
    logic ras_empty;

    assign ret_ok    = RET && !ras_empty;
    assign RAS_EMPTY = ras_empty;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (run_free && CALL),
        .pop       (run_free && ret_ok),
        .push_data (PC_OUT + XLEN'(INCR)),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    logic unused_ras_cfg;

    assign unused_ras_cfg = ^RAS_DEPTH ^ run_free;
    assign ret_ok         = 1'b0;
    assign ras_top        = '0;
`endif

    always_comb begin
        next_state = state;
        src        = SRC_HOLD;
        case (state)
            BOOT: begin
                next_state = RUN;
                if (TRAP) src = SRC_TRAP;
            end
            RUN: begin
                if (TRAP)                      src        = SRC_TRAP;
                else if (HALT_REQ)             next_state = HALT;
                else if (ret_ok)               src        = SRC_RET;
                else if (REDIRECT)             src        = SRC_REDIR;
                else if (PC_VALID && FETCH_READY) src     = SRC_INC;
            end
            HALT: begin
                if (TRAP) begin
                    src        = SRC_TRAP;
                    next_state = RUN;
                end else if (RESUME && !HALT_REQ) begin
                    next_state = RUN;
                end
            end
            default: next_state = BOOT;
        endcase
    end

    always_comb begin
        target        = '0;
        pc_next       = PC_OUT;
        misalign_next = 1'b0;
        case (src)
            SRC_TRAP:  target = TRAP_VECTOR;
            SRC_RET:   target = ras_top;
            SRC_REDIR: target = REDIRECT_TARGET;
            default:   target = '0;
        endcase
        case (src)
            SRC_INC: pc_next = PC_OUT + XLEN'(INCR);
            SRC_TRAP, SRC_RET, SRC_REDIR: begin
                pc_next       = target & ~ALIGN_MASK;
                misalign_next = |(target & ALIGN_MASK);
            end
            default: pc_next = PC_OUT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= BOOT;
            PC_OUT   <= RESET_VECTOR;
            PC_VALID <= 1'b0;
            HALTED   <= 1'b0;
            MISALIGN <= 1'b0;
        end else begin
            state    <= next_state;
            PC_OUT   <= pc_next;
            PC_VALID <= (next_state == RUN);
            HALTED   <= (next_state == HALT);
            MISALIGN <= misalign_next;
        end
    end

endmodule
